// File: rtl/lwc_host_port.sv
// Host-side port for the LWC core: buffers host PDI/SDI words toward the core,
// captures the core's DO stream for the host, and decodes the per-message
// status word into done/ok/word-count.

// Show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module lwc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         push, pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Full/empty come from registered pointers, so a write while full is
    // dropped even if a pop happens in the same cycle.
    assign push  = wr & ~full & ~clr;
    assign pop   = rd & ~empty & ~clr;
    // Head word is forced to zero while empty so idle outputs are quiet.
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; clear wins over any push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module lwc_host_port #(
    parameter int BUSW       = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [BUSW-1:0] h_pdi_data,
    input  logic            h_pdi_wr,
    output logic            h_pdi_full,
    input  logic [BUSW-1:0] h_sdi_data,
    input  logic            h_sdi_wr,
    output logic            h_sdi_full,
    output logic [BUSW-1:0] h_do_data,
    output logic            h_do_last,
    output logic            h_do_valid,
    input  logic            h_do_rd,
    output logic [BUSW-1:0] pdi_data,
    output logic            pdi_valid,
    input  logic            pdi_ready,
    output logic [BUSW-1:0] sdi_data,
    output logic            sdi_valid,
    input  logic            sdi_ready,
    input  logic [BUSW-1:0] do_data,
    input  logic            do_valid,
    input  logic            do_last,
    output logic            do_ready,
    output logic            msg_done,
    output logic            msg_ok,
    output logic [15:0]     msg_words
);
    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    logic   pdi_empty, sdi_empty, do_empty, do_full;
    logic   do_acc;
    state_t st, st_nxt;
    logic [15:0] cnt, cnt_nxt, words_nxt;
    logic   ok_nxt, done_nxt;

    lwc_fifo #(.W(BUSW), .DEPTH(FIFO_DEPTH)) u_pdi (
        .clk(clk), .rst(rst), .clr(flush),
        .wr(h_pdi_wr), .wdata(h_pdi_data), .full(h_pdi_full),
        .rd(pdi_ready), .rdata(pdi_data), .empty(pdi_empty)
    );

    lwc_fifo #(.W(BUSW), .DEPTH(FIFO_DEPTH)) u_sdi (
        .clk(clk), .rst(rst), .clr(flush),
        .wr(h_sdi_wr), .wdata(h_sdi_data), .full(h_sdi_full),
        .rd(sdi_ready), .rdata(sdi_data), .empty(sdi_empty)
    );

    // DO entries carry do_last as the top bit.
    lwc_fifo #(.W(BUSW+1), .DEPTH(FIFO_DEPTH)) u_do (
        .clk(clk), .rst(rst), .clr(flush),
        .wr(do_valid), .wdata({do_last, do_data}), .full(do_full),
        .rd(h_do_rd), .rdata({h_do_last, h_do_data}), .empty(do_empty)
    );

    assign pdi_valid  = ~pdi_empty;
    assign sdi_valid  = ~sdi_empty;
    assign h_do_valid = ~do_empty;
    assign do_ready   = ~do_full;
    assign do_acc     = do_valid & do_ready & ~flush;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Message tracker: counts accepted DO words and latches status on do_last.
    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        words_nxt = msg_words;
        ok_nxt    = msg_ok;
        done_nxt  = 1'b0;
        if (flush) begin
            st_nxt    = IDLE;
            cnt_nxt   = '0;
            words_nxt = '0;
            ok_nxt    = 1'b0;
        end else if (do_acc) begin
            if (do_last) begin
                // From IDLE the status word is the whole message.
                words_nxt = (st == RECV) ? sat_inc(cnt) : 16'd1;
                ok_nxt    = (do_data[BUSW-1 -: 4] == 4'hE);
                done_nxt  = 1'b1;
                st_nxt    = IDLE;
                cnt_nxt   = '0;
            end else if (st == IDLE) begin
                st_nxt  = RECV;
                cnt_nxt = 16'd1;
            end else begin
                cnt_nxt = sat_inc(cnt);
            end
        end
    end

    // Message tracker state and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            cnt       <= '0;
            msg_words <= '0;
            msg_ok    <= 1'b0;
            msg_done  <= 1'b0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            msg_words <= words_nxt;
            msg_ok    <= ok_nxt;
            msg_done  <= done_nxt;
        end
    end
endmodule

// File: tb/tb_lwc_host_port.sv
// Directed bench for lwc_host_port: a cycle-by-cycle vector table plus
// hand-written reset and pointer-wrap sequences.
module tb_lwc_host_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] h_pdi_data, h_sdi_data, h_do_data, pdi_data, sdi_data, do_data;
    logic        h_pdi_wr, h_pdi_full, h_sdi_wr, h_sdi_full;
    logic        h_do_last, h_do_valid, h_do_rd;
    logic        pdi_valid, pdi_ready, sdi_valid, sdi_ready;
    logic        do_valid, do_last, do_ready;
    logic        msg_done, msg_ok;
    logic [15:0] msg_words;

    lwc_host_port #(.BUSW(32), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .h_pdi_data(h_pdi_data), .h_pdi_wr(h_pdi_wr), .h_pdi_full(h_pdi_full),
        .h_sdi_data(h_sdi_data), .h_sdi_wr(h_sdi_wr), .h_sdi_full(h_sdi_full),
        .h_do_data(h_do_data), .h_do_last(h_do_last), .h_do_valid(h_do_valid),
        .h_do_rd(h_do_rd),
        .pdi_data(pdi_data), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
        .sdi_data(sdi_data), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
        .do_data(do_data), .do_valid(do_valid), .do_last(do_last), .do_ready(do_ready),
        .msg_done(msg_done), .msg_ok(msg_ok), .msg_words(msg_words)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        pwr;  logic [31:0] pd; logic prdy;
        logic        swr;  logic [31:0] sd; logic srdy;
        logic        dv;   logic [31:0] dd; logic dl;
        logic        hrd;
    } in_t;

    typedef struct packed {
        logic        pv;  logic [31:0] pd; logic pfull;
        logic        sv;  logic [31:0] sd; logic sfull;
        logic        hv;  logic [31:0] hd; logic hl;
        logic        drdy;
        logic        done; logic ok; logic [15:0] words;
    } ex_t;

    in_t vin[$];
    ex_t vex[$];
    in_t i;
    ex_t e, e_rst;
    int  n_pass = 0;
    int  n_chk  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic ex_t snap();
        ex_t s;
        s.pv = pdi_valid;  s.pd = pdi_data;  s.pfull = h_pdi_full;
        s.sv = sdi_valid;  s.sd = sdi_data;  s.sfull = h_sdi_full;
        s.hv = h_do_valid; s.hd = h_do_data; s.hl = h_do_last;
        s.drdy = do_ready;
        s.done = msg_done; s.ok = msg_ok; s.words = msg_words;
        return s;
    endfunction

    task automatic drive(input in_t x);
        flush = x.fl;
        h_pdi_wr = x.pwr; h_pdi_data = x.pd; pdi_ready = x.prdy;
        h_sdi_wr = x.swr; h_sdi_data = x.sd; sdi_ready = x.srdy;
        do_valid = x.dv;  do_data = x.dd;   do_last = x.dl;
        h_do_rd = x.hrd;
    endtask

    task automatic add();
        vin.push_back(i);
        vex.push_back(e);
    endtask

    initial begin
        // ---------------- vector table ----------------
        e_rst = '0; e_rst.drdy = 1'b1;
        // PDI backpressure: 8 writes fill the FIFO, 9th is dropped
        e = e_rst;
        for (int k = 1; k <= 8; k++) begin
            i = '0; i.pwr = 1'b1; i.pd = 32'h11111111 * k;
            e.pv = 1'b1; e.pd = 32'h11111111; e.pfull = (k == 8);
            add();
        end
        i = '0; i.pwr = 1'b1; i.pd = 32'h99999999; add();
        // drain one per cycle
        for (int k = 2; k <= 9; k++) begin
            i = '0; i.prdy = 1'b1;
            e.pfull = 1'b0;
            e.pv = (k <= 8); e.pd = (k <= 8) ? 32'h11111111 * k : 32'h0;
            add();
        end
        i = '0; i.prdy = 1'b1; add();          // dropped word must not appear
        // success message
        e = e_rst;
        i = '0; i.dv = 1; i.dd = 32'hAABBCCDD; e.hv = 1; e.hd = 32'hAABBCCDD; add();
        i.dd = 32'h01020304; add();
        i.dd = 32'hE0000000; i.dl = 1; e.done = 1; e.ok = 1; e.words = 16'd3; add();
        i = '0; i.hrd = 1; e.done = 0; e.hd = 32'h01020304; add();
        e.hd = 32'hE0000000; e.hl = 1; add();
        e.hv = 0; e.hd = 0; e.hl = 0; add();
        // failure, single-word message from IDLE
        i = '0; i.dv = 1; i.dd = 32'hF0000000; i.dl = 1;
        e.hv = 1; e.hd = 32'hF0000000; e.hl = 1; e.done = 1; e.ok = 0; e.words = 16'd1; add();
        i = '0; i.hrd = 1; e.hv = 0; e.hd = 0; e.hl = 0; e.done = 0; add();
        // fill DO FIFO with no host reads
        for (int k = 0; k < 8; k++) begin
            i = '0; i.dv = 1; i.dd = 32'h100 + k;
            e.hv = 1; e.hd = 32'h100; e.drdy = (k != 7);
            add();
        end
        i = '0; i.dv = 1; i.dd = 32'hE0000000; i.dl = 1; add();  // refused while full
        i.hrd = 1; e.hd = 32'h101; e.drdy = 1; add();              // pop only
        i.hrd = 0; e.drdy = 0; e.done = 1; e.ok = 1; e.words = 16'd9; add();
        // flush clears everything
        i = '0; i.fl = 1; e = e_rst; add();
        // flush collision
        i = '0; i.swr = 1; i.sd = 32'h5A5A5A5A; e.sv = 1; e.sd = 32'h5A5A5A5A; add();
        i = '0; i.srdy = 1; i.dv = 1; i.dd = 32'h1;
        e.sv = 0; e.sd = 0; e.hv = 1; e.hd = 32'h1; add();
        i = '0; i.fl = 1; i.swr = 1; i.sd = 32'h77; i.dv = 1; i.dd = 32'hE0000000; i.dl = 1;
        e = e_rst; add();
        i = '0; add();

        // ---------------- reset state ----------------
        drive('0);
        rst = 1'b0;
        #1 chk("reset_values", 128'(snap()), 128'(e_rst));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 128'(snap()), 128'(e_rst));

        // ---------------- table run ----------------
        for (int k = 0; k < vin.size(); k++) begin
            drive(vin[k]);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", k), 128'(snap()), 128'(vex[k]));
        end
        drive('0);

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 3; k++) begin
            h_pdi_wr = 1; h_pdi_data = 32'hC0 + k;
            @(posedge clk); #1;
        end
        h_pdi_wr = 0;
        chk("pdi_valid_before_reset", 128'(pdi_valid), 128'(1'b1));
        #2 rst = 1'b0;
        #1 chk("async_reset_values", 128'(snap()), 128'(e_rst));
        @(posedge clk); #1;
        chk("held_reset_values", 128'(snap()), 128'(e_rst));
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pdi_empty_after_reset", 128'(pdi_valid), 128'(1'b0));

        // ---------------- wrap-around, PDI and SDI ----------------
        begin
            logic [31:0] pq[$], sq[$];
            int p_sent = 0, s_sent = 0, p_got = 0, s_got = 0;
            for (int c = 0; c < 300 && (p_got < 20 || s_got < 20); c++) begin
                h_pdi_wr = (p_sent < 20) && ($urandom_range(0, 3) != 0);
                h_sdi_wr = (s_sent < 20) && ($urandom_range(0, 3) != 0);
                h_pdi_data = $urandom; h_sdi_data = $urandom;
                pdi_ready = $urandom_range(0, 1); sdi_ready = $urandom_range(0, 1);
                if (pdi_valid && pdi_ready) begin
                    chk("pdi_wrap_order", 128'(pdi_data), 128'(pq.size() ? pq[0] : 32'hX));
                    if (pq.size()) void'(pq.pop_front());
                    p_got++;
                end
                if (sdi_valid && sdi_ready) begin
                    chk("sdi_wrap_order", 128'(sdi_data), 128'(sq.size() ? sq[0] : 32'hX));
                    if (sq.size()) void'(sq.pop_front());
                    s_got++;
                end
                if (h_pdi_wr && !h_pdi_full) begin pq.push_back(h_pdi_data); p_sent++; end
                if (h_sdi_wr && !h_sdi_full) begin sq.push_back(h_sdi_data); s_sent++; end
                @(posedge clk); #1;
            end
            drive('0);
            chk("pdi_wrap_count", 128'(p_got), 128'(20));
            chk("sdi_wrap_count", 128'(s_got), 128'(20));
            @(posedge clk); #1;
            chk("wrap_drained", 128'({pdi_valid, sdi_valid}), 128'(2'b00));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lwc_host_port.md
# lwc_host_port

Host-side counterpart of the Romulus LWC core interface. Buffers host-written public-data and secret-data words in two FIFOs and drives them onto the core's `pdi`/`sdi` valid/ready inputs. Captures the core's `do` output stream, with `do_last` framing, into a third FIFO for the host. Decodes the final status word of each output message and reports completion, pass/fail and word count. The block sits between a bus/testbench master and the LWC top level and is the initiator for all three LWC streams.

## Interface
Parameters:
- `BUSW`, 32, LWC data bus width; must be ≥ 8.
- `FIFO_DEPTH`, 8, entries per FIFO; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all FIFOs, counters and status.
- `h_pdi_data`  in  BUSW  host word for the PDI FIFO.
- `h_pdi_wr`  in  1  write strobe, PDI FIFO.
- `h_pdi_full`  out  1  PDI FIFO full.
- `h_sdi_data`  in  BUSW  host word for the SDI FIFO.
- `h_sdi_wr`  in  1  write strobe, SDI FIFO.
- `h_sdi_full`  out  1  SDI FIFO full.
- `h_do_data`  out  BUSW  head word of the DO FIFO.
- `h_do_last`  out  1  head word was flagged `do_last`.
- `h_do_valid`  out  1  DO FIFO non-empty.
- `h_do_rd`  in  1  pop DO FIFO head.
- `pdi_data`  out  BUSW  to core.
- `pdi_valid`  out  1  to core.
- `pdi_ready`  in  1  from core.
- `sdi_data`  out  BUSW  to core.
- `sdi_valid`  out  1  to core.
- `sdi_ready`  in  1  from core.
- `do_data`  in  BUSW  from core.
- `do_valid`  in  1  from core.
- `do_last`  in  1  from core.
- `do_ready`  out  1  to core.
- `msg_done`  out  1  one-cycle pulse at the end of each output message.
- `msg_ok`  out  1  status of the last completed message; 1 = success.
- `msg_words`  out  16  words in the last completed message, status word included.

## Operation
- **FIFOs**
  - Three identical show-ahead FIFOs: PDI, SDI, and DO. The DO FIFO is BUSW+1 bits wide, with `do_last` stored as the extra bit.
  - Each FIFO has read/write pointers of width log2(FIFO_DEPTH)+1, so pointers wrap naturally and full/empty are distinguished by the MSB.
- **PDI/SDI write and read**
  - A write is accepted iff `h_*_wr` is high and the FIFO is not full, using the registered full flag. A write issued while full is dropped silently, even if a read occurs in the same cycle.
  - `pdi_valid` = PDI FIFO not empty. `pdi_data` = head word.
  - A pop occurs on `pdi_valid & pdi_ready`. SDI behaves identically.
- **DO capture**
  - `do_ready` = DO FIFO not full.
  - A word is pushed on `do_valid & do_ready`. Host pops on `h_do_rd & h_do_valid`. `h_do_rd` while empty is ignored.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- **Message state machine**, states IDLE and RECV:
  - IDLE → RECV on an accepted DO word with `do_last` = 0. The word counter loads 1.
  - RECV: each accepted DO word increments the word counter, saturating at 0xFFFF.
  - On an accepted word with `do_last` = 1, from either state:
    - `msg_words` ← counter + 1, saturating; this is 1 if the message arrived from IDLE.
    - `msg_ok` ← (`do_data[BUSW-1:BUSW-4]` == 4'hE).
    - `msg_done` pulses.
    - State → IDLE.
  - Any other status nibble, including 4'hF, yields `msg_ok` = 0.
- **Flush**
  - `flush` is synchronous and wins over every simultaneous write, read or capture.
  - Clears all pointers, state → IDLE, counter, `msg_ok` and `msg_words` to 0. No `msg_done` pulse.
- **Reset**
  - Asynchronous, active-low; same effect as `flush`, applied immediately.
  - Reset mid-message discards all buffered words.

## Timing
- Reset values of all outputs: `h_pdi_full` = 0, `h_sdi_full` = 0, `h_do_valid` = 0, `h_do_last` = 0, `h_do_data` = 0, `pdi_valid` = 0, `sdi_valid` = 0, `pdi_data` = 0, `sdi_data` = 0, `do_ready` = 1, `msg_done` = 0, `msg_ok` = 0, `msg_words` = 0.
- Host write to core: data written at edge N drives `pdi_valid` high from cycle N+1. Same for SDI.
- Core to host: DO word accepted at edge N appears on `h_do_valid`/`h_do_data` from cycle N+1.
- `msg_done`, `msg_ok` and `msg_words` update at the same edge as acceptance of the `do_last` word. `msg_done` is high for exactly that following cycle.
- Full flags are registered and assert the cycle after the write that filled the FIFO. `do_ready` deasserts the cycle after the DO FIFO fills.
- Sustained throughput is one word per cycle per stream, with no bubbles while the FIFO is neither empty nor full.
- FIFO data is held stable while valid is high and ready is low.

## Test plan
- **Reset/idle:** assert `rst` low mid-stream with 3 words in PDI → all outputs at reset values while low; `pdi_valid` stays 0 after release.
- **PDI backpressure:** write 0x11111111..0x88888888 (8 words) with `pdi_ready` = 0 → `h_pdi_full` = 1. A 9th write of 0x99999999 is dropped. Then `pdi_ready` = 1 → exactly the 8 words emerge in order, one per cycle.
- **Wrap-around:** on PDI and SDI, 20 interleaved writes/reads with random `pdi_ready`/`sdi_ready` → output sequence equals input sequence; no loss or duplication across pointer wrap.
- **Success message:** core sends 0xAABBCCDD, 0x01020304, then 0xE0000000 with `do_last` → one `msg_done` pulse, `msg_ok` = 1, `msg_words` = 3; host reads 3 words, `h_do_last` = 1 on the third.
- **Failure and single-word message:** core sends 0xF0000000 with `do_last` from IDLE → `msg_ok` = 0, `msg_words` = 1. DO FIFO full with `h_do_rd` = 0 → `do_ready` = 0 and no word accepted.
- **Flush collision:** `flush` in the same cycle as `h_sdi_wr` and an accepted DO `do_last` word → all FIFOs empty, `msg_done` = 0, `msg_words` = 0.
